// File: rtl/zstr_src.sv
// Queued stream source: each loaded value waits for its own programmed idle gap, then appears on
// a valid/ready bus. Optional transfer counter is enabled by the ZSTR_SRC_CNT_EN macro.
module zstr_src #(
    parameter int unsigned BW = 1,
    parameter logic        XZ = 1'bx,
    parameter int unsigned QL = 4,
    parameter int unsigned QW = $clog2(QL),
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_vld_i,
    input  logic [BW-1:0] ld_dat_i,
    input  logic [DW-1:0] ld_dly_i,
    output logic          ld_rdy_o,
    output logic          z_vld_o,
    output logic [BW-1:0] z_bus_o,
    input  logic          z_rdy_i,
    output logic [QW:0]   q_cnt_o,
    output logic [31:0]   trn_cnt_o
);

    localparam logic [QW:0]   QlCnt   = (QW+1)'(QL);
    localparam logic [QW-1:0] PtrLast = QW'(QL - 1);

    typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

    state_e               state_q, state_d;
    logic [DW+BW-1:0]     mem_q [QL];
    logic [QW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [QW:0]          cnt_q, cnt_d;
    logic [DW-1:0]        dly_q, dly_d;
    logic [BW-1:0]        out_q, out_d;
    logic                 push, pop, z_trn;
    logic [DW-1:0]        head_dly;
    logic [BW-1:0]        head_dat;

    assign {head_dly, head_dat} = mem_q[rd_ptr_q];
    assign push                 = ld_vld_i & ld_rdy_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        out_d   = out_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: pop = (cnt_q != '0);
            StWait: begin
                dly_d = dly_q - 1'b1;
                if (dly_q == DW'(1)) state_d = StSend;
            end
            StSend: begin
                if (z_trn) begin
                    if (cnt_q != '0) pop = 1'b1;
                    else             state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Popping the head overrides whatever the current state decided.
        if (pop) begin
            out_d   = head_dat;
            dly_d   = head_dly;
            state_d = (head_dly == '0) ? StSend : StWait;
        end
    end

    always_comb begin
        z_vld_o  = (state_q == StSend);
        z_bus_o  = z_vld_o ? out_q : {BW{XZ}};
        z_trn    = z_vld_o & z_rdy_i;
        ld_rdy_o = (cnt_q < QlCnt);
        q_cnt_o  = cnt_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dly_q    <= '0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dly_q    <= dly_d;
            out_q    <= out_d;
        end
    end

    // Storage needs no reset: only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {ld_dly_i, ld_dat_i};
    end

`ifdef ZSTR_SRC_CNT_EN
    logic [31:0] trn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trn_q <= '0;
        end else if (z_trn) begin
            trn_q <= trn_q + 32'd1;
        end
    end

    assign trn_cnt_o = trn_q;
`else
    assign trn_cnt_o = '0;
`endif

endmodule
